// File: rtl/beat_pkg.sv
// Shared definitions for the beat track engine: track state encoding,
// default sizing and the next-state rule shared by both tracks.
package beat_pkg;

  localparam int SAMPLE_W     = 4;
  localparam int DEPTH_DEF    = 512;
  localparam int TICK_DIV_DEF = 781250;

  typedef enum logic [1:0] {
    TRK_IDLE = 2'd0,
    TRK_REC  = 2'd1,
    TRK_PLAY = 2'd2
  } trk_state_t;

  // Record wins over load; with neither request the track idles.
  function automatic trk_state_t trk_next(input logic rec, input logic load);
    trk_state_t nxt;
    if (rec) begin
      nxt = TRK_REC;
    end else if (load) begin
      nxt = TRK_PLAY;
    end else begin
      nxt = TRK_IDLE;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/beat_track.sv
// One beat track: state machine, address/length counters, full flag and a
// DEPTH x SAMPLE_W synchronous RAM. The RAM read register is the track's
// contribution, so playback data appears one clock after the tick.
module beat_track
  import beat_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_tick,
  input  logic                i_record,
  input  logic                i_load,
  input  logic [SAMPLE_W-1:0] i_live,
  output logic [SAMPLE_W-1:0] o_sample,
  output logic                o_rec_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LEN_MAX = LW'(DEPTH);

  trk_state_t          r_state;
  trk_state_t          w_next;
  logic [AW-1:0]       r_addr;
  logic [LW-1:0]       r_len;
  logic                r_full;
  logic [SAMPLE_W-1:0] r_sample;
  logic [SAMPLE_W-1:0] r_mem [DEPTH];

  logic w_enter_rec;
  logic w_enter_play;
  logic w_wr_en;
  logic w_rd_en;
  logic w_addr_last;

  // Next state plus the entry, write and read strobes derived from it.
  always_comb begin
    w_next       = trk_next(i_record, i_load);
    w_enter_rec  = (w_next == TRK_REC) && (r_state != TRK_REC);
    w_enter_play = (w_next == TRK_PLAY) && (r_state != TRK_PLAY);
    w_wr_en      = (r_state == TRK_REC) && i_tick && (r_len < LEN_MAX);
    w_rd_en      = (r_state == TRK_PLAY) && (w_next == TRK_PLAY) && i_tick &&
                   (r_len != {LW{1'b0}});
    w_addr_last  = ({1'b0, r_addr} == (r_len - LW'(1)));
  end

  // Track state register, updated every clock from the control inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= TRK_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Recorded length and full flag; cleared on entry to REC, kept otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_len  <= {LW{1'b0}};
      r_full <= 1'b0;
    end else if (w_enter_rec) begin
      r_len  <= {LW{1'b0}};
      r_full <= 1'b0;
    end else if (w_wr_en) begin
      r_len  <= r_len + LW'(1);
      r_full <= (r_len == (LEN_MAX - LW'(1)));
    end else begin
      r_len  <= r_len;
      r_full <= r_full;
    end
  end

  // Sample address: restarts at 0 on entry to REC/PLAY, loops over len in PLAY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr <= {AW{1'b0}};
    end else if (w_enter_rec || w_enter_play) begin
      r_addr <= {AW{1'b0}};
    end else if (w_wr_en) begin
      r_addr <= r_addr + AW'(1);
    end else if (w_rd_en) begin
      r_addr <= w_addr_last ? {AW{1'b0}} : (r_addr + AW'(1));
    end else begin
      r_addr <= r_addr;
    end
  end

  // Track RAM write port; contents survive reset and are masked by len.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_addr] <= i_live;
    end
  end

  // RAM read register doubling as the contribution; zero outside steady PLAY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sample <= {SAMPLE_W{1'b0}};
    end else if ((w_next != TRK_PLAY) || (r_state != TRK_PLAY)) begin
      r_sample <= {SAMPLE_W{1'b0}};
    end else if (w_rd_en) begin
      r_sample <= r_mem[r_addr];
    end else begin
      r_sample <= r_sample;
    end
  end

  assign o_sample   = r_sample;
  assign o_rec_full = r_full;

endmodule

// File: rtl/beat_track_engine.sv
// Beat track engine top: sample-tick divider, KEY sync stage, two beat
// tracks and the registered OR mixer that feeds the sound/LED stage.
module beat_track_engine
  import beat_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int DEPTH    = DEPTH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                loadAFromRam,
  input  logic                loadBFromRam,
  input  logic                ramARecord,
  input  logic                ramBRecord,
  input  logic [SAMPLE_W-1:0] KEY,
  output logic [SAMPLE_W-1:0] beatOut,
  output logic                sampleTick,
  output logic                recFullA,
  output logic                recFullB
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_next;
  logic                r_tick;
  logic [SAMPLE_W-1:0] r_live;
  logic [SAMPLE_W-1:0] r_beat;
  logic [SAMPLE_W-1:0] w_sample_a;
  logic [SAMPLE_W-1:0] w_sample_b;

  // Divider next count, wrapping after TICK_DIV-1.
  always_comb begin
    if (r_cnt == CNT_LAST) begin
      w_cnt_next = {CW{1'b0}};
    end else begin
      w_cnt_next = r_cnt + CW'(1);
    end
  end

  // Divider counter and tick flag; the tick is high while the count is last.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= {CW{1'b0}};
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_tick <= (w_cnt_next == CNT_LAST);
    end
  end

  // KEY synchroniser; inverts so a pressed button reads as a 1 beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_live <= {SAMPLE_W{1'b0}};
    end else begin
      r_live <= ~KEY;
    end
  end

  beat_track #(.DEPTH(DEPTH)) u_track_a (
    .clk        (clk),
    .reset      (reset),
    .i_tick     (r_tick),
    .i_record   (ramARecord),
    .i_load     (loadAFromRam),
    .i_live     (r_live),
    .o_sample   (w_sample_a),
    .o_rec_full (recFullA)
  );

  beat_track #(.DEPTH(DEPTH)) u_track_b (
    .clk        (clk),
    .reset      (reset),
    .i_tick     (r_tick),
    .i_record   (ramBRecord),
    .i_load     (loadBFromRam),
    .i_live     (r_live),
    .o_sample   (w_sample_b),
    .o_rec_full (recFullB)
  );

  // Output mixer: live beats overlaid with both track contributions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_beat <= {SAMPLE_W{1'b0}};
    end else begin
      r_beat <= r_live | w_sample_a | w_sample_b;
    end
  end

  assign beatOut    = r_beat;
  assign sampleTick = r_tick;

endmodule

// File: tb/tb_beat_track_engine.sv
// Self-checking bench for beat_track_engine with TICK_DIV=4, DEPTH=8.
// Expected beat values are pushed to a scoreboard queue when playback is
// started and popped at tick+2, where the DUT presents them on beatOut.
module tb_beat_track_engine;

  logic       clk;
  logic       reset;
  logic       loadAFromRam;
  logic       loadBFromRam;
  logic       ramARecord;
  logic       ramBRecord;
  logic [3:0] KEY;
  logic [3:0] beatOut;
  logic       sampleTick;
  logic       recFullA;
  logic       recFullB;

  int n_tests;
  int n_fail;
  logic [3:0] sb_q [$];
  logic [3:0] stim [16];

  beat_track_engine #(.TICK_DIV(4), .DEPTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .loadAFromRam (loadAFromRam),
    .loadBFromRam (loadBFromRam),
    .ramARecord   (ramARecord),
    .ramBRecord   (ramBRecord),
    .KEY          (KEY),
    .beatOut      (beatOut),
    .sampleTick   (sampleTick),
    .recFullA     (recFullA),
    .recFullB     (recFullB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the falling edge of the next tick cycle (bounded).
  task automatic wait_tick();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!sampleTick && k < 20);
    if (!sampleTick) begin
      n_tests++;
      n_fail++;
      $display("FAIL tick_timeout: no sampleTick within %0d cycles, required one within 20", k);
    end
  endtask

  // Advance to the sample point where a tick's playback shows on beatOut.
  task automatic wait_out();
    wait_tick();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_rec(input bit trk_b, input logic v);
    if (trk_b) ramBRecord = v;
    else       ramARecord = v;
  endtask

  // Record n samples from stim[] into a track; optionally keep record high.
  task automatic do_record(input bit trk_b, input int n, input bit keep);
    wait_tick();
    set_rec(trk_b, 1'b1);
    KEY = ~stim[0];
    for (int i = 0; i < n; i++) begin
      wait_tick();
      if (i < n - 1) begin
        KEY = ~stim[i + 1];
      end else begin
        KEY = 4'hF;
        if (!keep) set_rec(trk_b, 1'b0);
      end
    end
  endtask

  task automatic test_reset();
    int k;
    reset = 1'b1;
    loadAFromRam = 1'b0; loadBFromRam = 1'b0;
    ramARecord = 1'b0;   ramBRecord = 1'b0;
    KEY = 4'h0;
    repeat (3) @(negedge clk);
    n_tests++; if (beatOut !== 4'b0000) begin n_fail++; $display("FAIL reset_beat: beatOut=%b expected 0000", beatOut); end
    n_tests++; if (sampleTick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: sampleTick=%b expected 0", sampleTick); end
    n_tests++; if (recFullA !== 1'b0) begin n_fail++; $display("FAIL reset_fullA: recFullA=%b expected 0", recFullA); end
    n_tests++; if (recFullB !== 1'b0) begin n_fail++; $display("FAIL reset_fullB: recFullB=%b expected 0", recFullB); end
    KEY = 4'hF;
    reset = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!sampleTick && k < 20);
    n_tests++; if (k !== 3) begin n_fail++; $display("FAIL first_tick: cycles=%0d expected 3", k); end
    @(negedge clk);
    n_tests++; if (sampleTick !== 1'b0) begin n_fail++; $display("FAIL tick_pulse: sampleTick=%b expected 0", sampleTick); end
    k = 1;
    while (!sampleTick && k < 20) begin @(negedge clk); k++; end
    n_tests++; if (k !== 4) begin n_fail++; $display("FAIL tick_period: cycles=%0d expected 4", k); end
  endtask

  task automatic test_reset_mid_record();
    logic [3:0] exp_v;
    stim[0] = 4'b0011; stim[1] = 4'b0101; stim[2] = 4'b1001;
    do_record(1'b0, 3, 1'b1);
    KEY = 4'h0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    n_tests++; if (beatOut !== 4'b1111) begin n_fail++; $display("FAIL midrec_live: beatOut=%b expected 1111", beatOut); end
    reset = 1'b1;
    ramARecord = 1'b0;
    #1;
    n_tests++; if (beatOut !== 4'b0000) begin n_fail++; $display("FAIL midrec_reset_beat: beatOut=%b expected 0000", beatOut); end
    n_tests++; if (sampleTick !== 1'b0) begin n_fail++; $display("FAIL midrec_reset_tick: sampleTick=%b expected 0", sampleTick); end
    @(negedge clk);
    KEY = 4'hF;
    reset = 1'b0;
    loadAFromRam = 1'b1;
    for (int i = 0; i < 4; i++) sb_q.push_back(4'b0000);
    for (int i = 0; i < 4; i++) begin
      wait_out();
      exp_v = sb_q.pop_front();
      n_tests++;
      if (beatOut !== exp_v) begin n_fail++; $display("FAIL midrec_play[%0d]: beatOut=%b expected %b", i, beatOut, exp_v); end
    end
    loadAFromRam = 1'b0;
  endtask

  task automatic test_record_loop_a();
    logic [3:0] exp_v;
    stim[0] = 4'b0001; stim[1] = 4'b0010; stim[2] = 4'b0100;
    do_record(1'b0, 3, 1'b0);
    @(negedge clk);
    loadAFromRam = 1'b1;
    for (int i = 0; i < 7; i++) sb_q.push_back(stim[i % 3]);
    for (int i = 0; i < 7; i++) begin
      wait_out();
      exp_v = sb_q.pop_front();
      n_tests++;
      if (beatOut !== exp_v) begin n_fail++; $display("FAIL loopA[%0d]: beatOut=%b expected %b", i, beatOut, exp_v); end
    end
    loadAFromRam = 1'b0;
  endtask

  task automatic test_full_track();
    logic [3:0] exp_v;
    for (int i = 0; i < 10; i++) stim[i] = 4'(i + 1);
    wait_tick();
    ramBRecord = 1'b1;
    KEY = ~stim[0];
    for (int i = 0; i < 10; i++) begin
      wait_tick();
      if (i < 9) begin
        KEY = ~stim[i + 1];
      end else begin
        KEY = 4'hF;
        ramBRecord = 1'b0;
      end
      @(negedge clk);
      n_tests++;
      if (recFullB !== (i >= 7)) begin n_fail++; $display("FAIL fullB_flag[%0d]: recFullB=%b expected %b", i, recFullB, (i >= 7)); end
    end
    @(negedge clk);
    loadBFromRam = 1'b1;
    for (int i = 0; i < 10; i++) sb_q.push_back(stim[i % 8]);
    for (int i = 0; i < 10; i++) begin
      wait_out();
      exp_v = sb_q.pop_front();
      n_tests++;
      if (beatOut !== exp_v) begin n_fail++; $display("FAIL fullB_play[%0d]: beatOut=%b expected %b", i, beatOut, exp_v); end
    end
    loadBFromRam = 1'b0;
  endtask

  task automatic test_priority();
    logic [3:0] exp_v;
    stim[0] = 4'b1000; stim[1] = 4'b1000; stim[2] = 4'b1100;
    wait_tick();
    ramARecord = 1'b1;
    loadAFromRam = 1'b1;
    KEY = ~stim[0];
    for (int i = 0; i < 3; i++) begin
      wait_tick();
      if (i < 2) begin
        KEY = ~stim[i + 1];
        exp_v = stim[i + 1];
      end else begin
        KEY = 4'hF;
        ramARecord = 1'b0;
        exp_v = 4'b0000;
      end
      @(posedge clk); @(posedge clk); @(negedge clk);
      n_tests++;
      if (beatOut !== exp_v) begin n_fail++; $display("FAIL prio_rec[%0d]: beatOut=%b expected %b", i, beatOut, exp_v); end
    end
    n_tests++; if (recFullA !== 1'b0) begin n_fail++; $display("FAIL prio_full: recFullA=%b expected 0", recFullA); end
    for (int i = 0; i < 4; i++) sb_q.push_back(stim[i % 3]);
    for (int i = 0; i < 4; i++) begin
      wait_out();
      exp_v = sb_q.pop_front();
      n_tests++;
      if (beatOut !== exp_v) begin n_fail++; $display("FAIL prio_play[%0d]: beatOut=%b expected %b", i, beatOut, exp_v); end
    end
    loadAFromRam = 1'b0;
  endtask

  task automatic test_mix();
    logic [3:0] exp_v;
    stim[0] = 4'b0001;
    do_record(1'b0, 1, 1'b0);
    stim[0] = 4'b0100;
    do_record(1'b1, 1, 1'b0);
    @(negedge clk);
    loadAFromRam = 1'b1;
    loadBFromRam = 1'b1;
    KEY = 4'b0111;
    for (int i = 0; i < 3; i++) sb_q.push_back(4'b1101);
    for (int i = 0; i < 3; i++) begin
      wait_out();
      exp_v = sb_q.pop_front();
      n_tests++;
      if (beatOut !== exp_v) begin n_fail++; $display("FAIL mix[%0d]: beatOut=%b expected %b", i, beatOut, exp_v); end
    end
    loadAFromRam = 1'b0;
    loadBFromRam = 1'b0;
    KEY = 4'hF;
  endtask

  task automatic test_restart();
    logic [3:0] exp_v;
    stim[0] = 4'b0001; stim[1] = 4'b0010; stim[2] = 4'b0100;
    do_record(1'b0, 3, 1'b0);
    @(negedge clk);
    loadAFromRam = 1'b1;
    sb_q.push_back(stim[0]);
    sb_q.push_back(stim[1]);
    for (int i = 0; i < 2; i++) begin
      wait_out();
      exp_v = sb_q.pop_front();
      n_tests++;
      if (beatOut !== exp_v) begin n_fail++; $display("FAIL restart_pre[%0d]: beatOut=%b expected %b", i, beatOut, exp_v); end
    end
    loadAFromRam = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    n_tests++; if (beatOut !== 4'b0000) begin n_fail++; $display("FAIL restart_gap: beatOut=%b expected 0000", beatOut); end
    wait_out();
    n_tests++; if (beatOut !== 4'b0000) begin n_fail++; $display("FAIL restart_idle: beatOut=%b expected 0000", beatOut); end
    loadAFromRam = 1'b1;
    sb_q.push_back(stim[0]);
    sb_q.push_back(stim[1]);
    sb_q.push_back(stim[2]);
    for (int i = 0; i < 3; i++) begin
      wait_out();
      exp_v = sb_q.pop_front();
      n_tests++;
      if (beatOut !== exp_v) begin n_fail++; $display("FAIL restart_post[%0d]: beatOut=%b expected %b", i, beatOut, exp_v); end
    end
    loadAFromRam = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_reset_mid_record();
    test_record_loop_a();
    test_full_track();
    test_priority();
    test_mix();
    test_restart();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/beat_track_engine.md
# beat_track_engine

Datapath consumer of the record/playback control lines produced by the beat recorder's mode FSM. Holds two independent beat tracks (A and B) in on-chip RAM, records live KEY presses into a track at a fixed sample rate, loops recorded tracks back, and mixes live and replayed beats into one 4-bit beat vector for the sound/LED stage.

## Interface
- `TICK_DIV`, default 781250: clk cycles per sample tick (15.625 ms at 50 MHz; 64 Hz sampling).
- `DEPTH`, default 512: samples per track; power of two, ≥ 4.
- `clk`  in  1  system clock; the block uses only this clock.
- `reset`  in  1  asynchronous, active-high reset.
- `loadAFromRam`  in  1  play track A in a loop while high.
- `loadBFromRam`  in  1  play track B in a loop while high.
- `ramARecord`  in  1  record into track A while high.
- `ramBRecord`  in  1  record into track B while high.
- `KEY`  in  4  board pushbuttons, active-low; pressed = 0.
- `beatOut`  out  4  registered mix: live OR playA OR playB, 1 = beat.
- `sampleTick`  out  1  one-cycle pulse per sample period.
- `recFullA`  out  1  track A reached DEPTH samples during the current/last recording.
- `recFullB`  out  1  same for track B.

## Operation
- Tick counter runs 0..TICK_DIV-1 and wraps; `sampleTick` = 1 in the cycle where count == TICK_DIV-1.
- Live sample `live = ~KEY`, registered once (sync stage) before any use.
- Per-track FSM, states IDLE, REC, PLAY; next state evaluated every clk:
  - record input high → REC (record has priority over load for the same track).
  - else load input high → PLAY.
  - else → IDLE.
- Entering REC (from any state): addr ← 0, len ← 0, recFull ← 0.
- In REC, on each tick with len < DEPTH: mem[addr] ← live, addr++, len++. On the write making len == DEPTH: recFull ← 1; later ticks write nothing, and len holds at DEPTH.
- Leaving REC: len is kept; mem contents are kept.
- Entering PLAY: addr ← 0. In PLAY, on each tick: read mem[addr]. Then addr ← (addr == len-1) ? 0 : addr+1 (loop).
- PLAY with len == 0: no reads; the track contributes 0.
- Track contribution is 0 in IDLE and REC. In PLAY it holds the last read sample until the next tick.
- `beatOut` = live | trackA | trackB, registered.
- Length counter width is clog2(DEPTH)+1, so DEPTH itself is representable. Address width is clog2(DEPTH).
- Mid-operation state change (e.g. load dropped during PLAY): the contribution goes to 0 on the next clk and addr is not preserved. Re-entry starts at sample 0.

## Timing
- Reset values: `beatOut` 0, `sampleTick` 0, `recFullA/B` 0, both FSMs IDLE, addr/len 0, tick counter 0. RAM contents are not cleared; len = 0 masks them.
- Control inputs are sampled on the clk edge. State changes one cycle after an input change.
- Record latency: the KEY sample captured by the sync register in the cycle of `sampleTick` is written in that same cycle.
- Playback latency: synchronous RAM read issued on the tick cycle; data is registered into the track contribution one cycle later; `beatOut` updates one further cycle later (tick + 2).
- Live path latency: KEY → sync reg → `beatOut` = 2 clk.
- Record and play on different tracks in the same tick are independent. A single track never reads and writes in the same cycle.

## Structure
- Shared package `beat_pkg`:
  - track state encoding (IDLE, REC, PLAY)
  - defaults for `DEPTH`, `TICK_DIV`
  - sample width constant (4)
- Sub-module `beat_track`: one track, containing its FSM, addr/len counters, recFull flag, and DEPTH×4 synchronous RAM. Instantiated twice.
- Top level holds the tick divider, KEY sync stage, and output mixer.

## Test plan
All scenarios use TICK_DIV=4, DEPTH=8.
- Reset mid-recording: assert reset after 3 A samples. All outputs go to 0 immediately. After release, `loadAFromRam`=1 gives `beatOut` = 0 forever (len = 0).
- Record then loop A: hold `ramARecord` for 3 ticks with KEY = 1110, 1101, 1011; drop it; raise `loadAFromRam`. `beatOut` cycles 0001, 0010, 0100, 0001… each at tick+2.
- Full track: hold `ramBRecord` for 10 ticks with live varying. `recFullB` rises on the 8th write. Playback of B loops exactly 8 samples; samples 9–10 are absent.
- Priority: `ramARecord`=`loadAFromRam`=1. Track A records (len increments) and contributes 0.
- Mix: A plays 0001, B plays 0100, KEY[3] pressed. `beatOut` = 1101.
- Restart: drop `loadAFromRam` mid-loop at sample 2 and re-raise it. Playback resumes at sample 0, and `beatOut` is 0 in between.
